// File: rtl/trig_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trig_seq_pkg
//  Purpose  : Shared definitions for the trigger command sequencer: the FSM
//             state encoding, the WAIT_BUSY timeout and default field widths.
//  Revision : 1.0 - initial release
// ============================================================================
package trig_seq_pkg;

    localparam int DEFAULT_DUR_W     = 11;
    localparam int DEFAULT_DEL_W     = 21;

    // Cycles spent in WAIT_BUSY waiting for trig_complete to drop before the
    // sequencer assumes a zero-length command and moves on.
    localparam int WAIT_BUSY_TIMEOUT = 4;
    localparam int WB_CNT_W          = $clog2(WAIT_BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_MARK      = 3'd2,
        ST_GO        = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_RELEASE   = 3'd6
    } seq_state_t;

endpackage : trig_seq_pkg
`default_nettype wire

// File: rtl/trig_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : trig_cmd_fifo
//  Purpose  : Command buffer. Entries are appended at the write pointer and
//             read back non-destructively through a random-access read port,
//             so the same buffer can be replayed any number of times.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             wr_en/wr_data - append one entry (ignored when full)
//             rd_addr       - read address, rd_data is combinational
//             count, full   - number of stored entries, saturates at DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module trig_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic             push;

    assign push    = wr_en && !full;
    assign full    = (count == FULL_COUNT);
    assign rd_data = mem[rd_addr];

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer wraps modulo DEPTH (power of two); count cannot pass DEPTH
    // because pushes are blocked while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
        end
    end

endmodule : trig_cmd_fifo
`default_nettype wire

// File: rtl/trig_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : trig_cmd_sequencer
//  Purpose  : Buffers {delay, duration} trigger commands and plays them back
//             to a downstream trigger/LED stage using the on_your_mark /
//             gogogo / trig_rst handshake, one command at a time.
//  Ports    : clk, rst                  - clock, asynchronous active-high reset
//             wr_en, wr_delay, wr_duration - command push (accepted in IDLE)
//             start, abort              - play request / level abort
//             trig_complete             - downstream completion flag
//             on_your_mark, gogogo, trig_rst - downstream controls
//             duration, delay           - registered current command
//             busy, done, full, count   - status
//  Option   : TRIG_SEQ_LOOP_EN adds input loop_count[15:0]; the buffer is
//             replayed loop_count+1 times per start.
//  Revision : 1.0 - initial release
// ============================================================================
module trig_cmd_sequencer
    import trig_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DUR_W = DEFAULT_DUR_W,
    parameter int DEL_W = DEFAULT_DEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DUR_W-1:0]       wr_duration,
    input  logic [DEL_W-1:0]       wr_delay,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   trig_complete,
`ifdef TRIG_SEQ_LOOP_EN
    input  logic [15:0]            loop_count,
`endif
    output logic                   on_your_mark,
    output logic                   gogogo,
    output logic                   trig_rst,
    output logic [DUR_W-1:0]       duration,
    output logic [DEL_W-1:0]       delay,
    output logic                   busy,
    output logic                   done,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DEL_W + DUR_W;
    localparam logic [WB_CNT_W-1:0] WB_LAST = WB_CNT_W'(WAIT_BUSY_TIMEOUT - 1);

    seq_state_t          state;
    logic [CW-1:0]       rd_ptr;
    logic [CW-1:0]       next_ptr;
    logic [WB_CNT_W-1:0] wb_cnt;
    logic                aborting;
    logic [EW-1:0]       rd_data;
    logic                push_req;
`ifdef TRIG_SEQ_LOOP_EN
    logic [15:0]         loops_left;
`endif

    // Commands are only accepted while idle so the buffer is stable during
    // playback.
    assign push_req = wr_en && (state == ST_IDLE);
    assign next_ptr = rd_ptr + 1'b1;

    trig_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_req),
        .wr_data ({wr_delay, wr_duration}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data),
        .count   (count),
        .full    (full)
    );

    // Outputs are registered on entry to the state that owns them, so each
    // state sees its own control values for its whole duration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rd_ptr       <= '0;
            wb_cnt       <= '0;
            aborting     <= 1'b0;
            on_your_mark <= 1'b0;
            gogogo       <= 1'b0;
            trig_rst     <= 1'b1;
            duration     <= '0;
            delay        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef TRIG_SEQ_LOOP_EN
            loops_left   <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Abort beats everything except an abort already in progress:
            // route through RELEASE for its single trig_rst cycle.
            if ((state != ST_IDLE) && !aborting && abort) begin
                on_your_mark <= 1'b0;
                gogogo       <= 1'b0;
                trig_rst     <= 1'b1;
                aborting     <= 1'b1;
                state        <= ST_RELEASE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        trig_rst <= 1'b0;
                        if (start && !abort) begin
                            if (count != '0) begin
                                state  <= ST_LOAD;
                                busy   <= 1'b1;
                                rd_ptr <= '0;
`ifdef TRIG_SEQ_LOOP_EN
                                loops_left <= loop_count;
`endif
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        {delay, duration} <= rd_data;
                        on_your_mark      <= 1'b1;
                        gogogo            <= 1'b0;
                        state             <= ST_MARK;
                    end
                    ST_MARK: begin
                        gogogo <= 1'b1;
                        state  <= ST_GO;
                    end
                    ST_GO: begin
                        wb_cnt <= '0;
                        state  <= ST_WAIT_BUSY;
                    end
                    ST_WAIT_BUSY: begin
                        // A zero-length command may never drop
                        // trig_complete; give up waiting after the timeout.
                        if (!trig_complete || (wb_cnt == WB_LAST)) begin
                            state <= ST_WAIT_DONE;
                        end else begin
                            wb_cnt <= wb_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (trig_complete) begin
                            on_your_mark <= 1'b0;
                            gogogo       <= 1'b0;
                            trig_rst     <= 1'b1;
                            state        <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        trig_rst <= 1'b0;
                        if (aborting) begin
                            aborting <= 1'b0;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else if (next_ptr < count) begin
                            rd_ptr <= next_ptr;
                            state  <= ST_LOAD;
`ifdef TRIG_SEQ_LOOP_EN
                        end else if (loops_left != 16'd0) begin
                            loops_left <= loops_left - 16'd1;
                            rd_ptr     <= '0;
                            state      <= ST_LOAD;
`endif
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule : trig_cmd_sequencer
`default_nettype wire

// File: tb/tb_trig_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trig_cmd_sequencer
//  Purpose  : Directed self-checking bench for trig_cmd_sequencer with a
//             simple downstream model: on a rising gogogo it drops
//             trig_complete for run_len cycles (run_len=0 never drops it).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trig_cmd_sequencer;

    localparam int DEPTH = 16;
    localparam int DUR_W = 11;
    localparam int DEL_W = 21;
    localparam int CW    = 5;
    localparam int EW    = DEL_W + DUR_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [DUR_W-1:0] wr_duration;
    logic [DEL_W-1:0] wr_delay;
    logic             start;
    logic             abort;
    logic             trig_complete;
`ifdef TRIG_SEQ_LOOP_EN
    logic [15:0]      loop_count;
`endif
    logic             on_your_mark;
    logic             gogogo;
    logic             trig_rst;
    logic [DUR_W-1:0] duration;
    logic [DEL_W-1:0] delay;
    logic             busy;
    logic             done;
    logic             full;
    logic [CW-1:0]    count;

    int checks   = 0;
    int failures = 0;

    trig_cmd_sequencer #(
        .DEPTH (DEPTH),
        .DUR_W (DUR_W),
        .DEL_W (DEL_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_duration   (wr_duration),
        .wr_delay      (wr_delay),
        .start         (start),
        .abort         (abort),
        .trig_complete (trig_complete),
`ifdef TRIG_SEQ_LOOP_EN
        .loop_count    (loop_count),
`endif
        .on_your_mark  (on_your_mark),
        .gogogo        (gogogo),
        .trig_rst      (trig_rst),
        .duration      (duration),
        .delay         (delay),
        .busy          (busy),
        .done          (done),
        .full          (full),
        .count         (count)
    );

    always #5 clk = ~clk;

    // ---------------- downstream model ----------------
    int   run_len = 8;
    logic model_prev_go = 1'b0;
    int   model_cnt = 0;
    initial begin
        trig_complete = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (gogogo && !model_prev_go) begin
                if (run_len > 0) begin
                    trig_complete = 1'b0;
                    model_cnt     = run_len;
                end
            end else if (!trig_complete) begin
                model_cnt = model_cnt - 1;
                if (model_cnt <= 0) trig_complete = 1'b1;
            end
            model_prev_go = gogogo;
        end
    end

    // ---------------- observation monitor ----------------
    int        mark_cnt, done_cnt, trst_cnt, busy_low, mark_bad;
    bit        track_busy = 1'b0;
    logic      prev_omk = 1'b0;
    logic [EW-1:0] cap_q[$];
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (on_your_mark && !prev_omk) begin
                mark_cnt++;
                cap_q.push_back({delay, duration});
                if (gogogo) mark_bad++;
            end
            if (done)     done_cnt++;
            if (trig_rst) trst_cnt++;
            if (track_busy && !busy && !done) busy_low++;
            prev_omk = on_your_mark;
        end
    end

    function automatic logic [EW-1:0] get_cap(input int i);
        if (i < cap_q.size()) return cap_q[i];
        return '1;
    endfunction

    task automatic clear_mon();
        mark_cnt = 0; done_cnt = 0; trst_cnt = 0; busy_low = 0; mark_bad = 0;
        cap_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
    endtask

    task automatic push(input int del, input int dur);
        wr_en       = 1'b1;
        wr_delay    = DEL_W'(del);
        wr_duration = DUR_W'(dur);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Leaves the bench at the first negedge after the start edge (k=0).
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the negedge index at which done is seen, -1 on timeout.
    task automatic wait_done(input int budget, output int k);
        k = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({on_your_mark, gogogo, trig_rst, busy, done} !== 5'b00100) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 00100", {on_your_mark, gogogo, trig_rst, busy, done}); end
        checks++; if ({duration, delay} !== '0) begin
            failures++; $display("FAIL reset_cmd: got dur=%0d del=%0d expected 0/0", duration, delay); end
        checks++; if ({full, count} !== 6'd0) begin
            failures++; $display("FAIL reset_count: got full=%0d count=%0d expected 0/0", full, count); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (trig_rst !== 1'b0) begin
            failures++; $display("FAIL reset_release_trig_rst: got %0d expected 0", trig_rst); end
        clear_mon();
    endtask

    task automatic test_playback();
        int k;
        do_reset();
        run_len = 8;
        push(5, 3); push(6, 2); push(7, 1);
        checks++; if (count !== 5'd3) begin
            failures++; $display("FAIL play_count: got %0d expected 3", count); end
        pulse_start();
        track_busy = 1'b1;
        push(9, 9);                       // dropped: not idle
        wait_done(200, k);
        track_busy = 1'b0;
        checks++; if (k !== 35) begin
            failures++; $display("FAIL play_latency: done at %0d expected 35", k); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mark_cnt !== 3 || mark_bad !== 0) begin
            failures++; $display("FAIL play_marks: got %0d bad=%0d expected 3 bad=0", mark_cnt, mark_bad); end
        checks++; if (done_cnt !== 1) begin
            failures++; $display("FAIL play_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (trst_cnt !== 3) begin
            failures++; $display("FAIL play_trig_rst: got %0d expected 3", trst_cnt); end
        checks++; if (busy_low !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL play_busy: got low=%0d end=%0d expected 0/0", busy_low, busy); end
        checks++; if (get_cap(0) !== {21'd5, 11'd3} || get_cap(1) !== {21'd6, 11'd2} || get_cap(2) !== {21'd7, 11'd1}) begin
            failures++; $display("FAIL play_order: got %h %h %h expected 5/3 6/2 7/1", get_cap(0), get_cap(1), get_cap(2)); end
        checks++; if (count !== 5'd3) begin
            failures++; $display("FAIL play_busy_push: got count %0d expected 3", count); end
    endtask

    task automatic test_full();
        int k;
        do_reset();
        run_len = 2;
        for (int i = 0; i < 17; i++) push(100 + i, i);
        checks++; if (full !== 1'b1 || count !== 5'd16) begin
            failures++; $display("FAIL full_flag: got full=%0d count=%0d expected 1/16", full, count); end
        pulse_start();
        wait_done(300, k);
        checks++; if (k !== 96) begin
            failures++; $display("FAIL full_latency: done at %0d expected 96", k); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mark_cnt !== 16) begin
            failures++; $display("FAIL full_marks: got %0d expected 16", mark_cnt); end
        checks++; if (get_cap(0) !== {21'd100, 11'd0} || get_cap(15) !== {21'd115, 11'd15}) begin
            failures++; $display("FAIL full_entries: got %h %h expected 100/0 115/15", get_cap(0), get_cap(15)); end
    endtask

    task automatic test_empty_start();
        int k;
        do_reset();
        pulse_start();
        wait_done(10, k);
        checks++; if (k !== 0) begin
            failures++; $display("FAIL empty_done: done at %0d expected 0", k); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL empty_pulse: got done=%0d busy=%0d expected 0/0", done, busy); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (mark_cnt !== 0 || done_cnt !== 1) begin
            failures++; $display("FAIL empty_marks: got marks=%0d dones=%0d expected 0/1", mark_cnt, done_cnt); end
    endtask

    task automatic test_abort();
        int k;
        do_reset();
        run_len = 8;
        push(5, 3); push(6, 2); push(7, 1);
        pulse_start();
        repeat (18) @(negedge clk);       // inside WAIT_DONE of command 2
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({on_your_mark, gogogo, trig_rst} !== 3'b001) begin
            failures++; $display("FAIL abort_release: got %b expected 001", {on_your_mark, gogogo, trig_rst}); end
        @(negedge clk);
        checks++; if ({trig_rst, busy, done} !== 3'b000) begin
            failures++; $display("FAIL abort_idle: got %b expected 000", {trig_rst, busy, done}); end
        repeat (12) @(negedge clk);
        #1;
        checks++; if (done_cnt !== 0 || mark_cnt !== 2) begin
            failures++; $display("FAIL abort_nodone: got dones=%0d marks=%0d expected 0/2", done_cnt, mark_cnt); end
        clear_mon();
        pulse_start();
        wait_done(200, k);
        checks++; if (k !== 36) begin
            failures++; $display("FAIL abort_replay_latency: done at %0d expected 36", k); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mark_cnt !== 3 || get_cap(0) !== {21'd5, 11'd3}) begin
            failures++; $display("FAIL abort_replay: got marks=%0d first=%h expected 3/5,3", mark_cnt, get_cap(0)); end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        run_len = 0;
        push(0, 0);
        pulse_start();
        wait_done(50, k);
        checks++; if (k !== 9) begin
            failures++; $display("FAIL timeout_latency: done at %0d expected 9", k); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mark_cnt !== 1 || done_cnt !== 1) begin
            failures++; $display("FAIL timeout_marks: got marks=%0d dones=%0d expected 1/1", mark_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid_playback();
        int k;
        do_reset();
        run_len = 8;
        push(4, 4); push(3, 3);
        pulse_start();
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({on_your_mark, gogogo, trig_rst, busy} !== 4'b0010 || count !== 5'd0 || {duration, delay} !== '0) begin
            failures++; $display("FAIL midreset_async: got ctl=%b count=%0d dur=%0d del=%0d expected 0010/0/0/0",
                {on_your_mark, gogogo, trig_rst, busy}, count, duration, delay); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        clear_mon();
        pulse_start();
        wait_done(10, k);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (k !== 0 || mark_cnt !== 0) begin
            failures++; $display("FAIL midreset_discard: done at %0d marks=%0d expected 0/0", k, mark_cnt); end
    endtask

`ifdef TRIG_SEQ_LOOP_EN
    task automatic test_loop();
        int k;
        do_reset();
        run_len = 8;
        push(5, 3); push(6, 2);
        loop_count = 16'd2;
        pulse_start();
        wait_done(300, k);
        repeat (2) @(negedge clk);
        #1;
        loop_count = 16'd0;
        checks++; if (k !== 72) begin
            failures++; $display("FAIL loop_latency: done at %0d expected 72", k); end
        checks++; if (mark_cnt !== 6 || done_cnt !== 1) begin
            failures++; $display("FAIL loop_marks: got marks=%0d dones=%0d expected 6/1", mark_cnt, done_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_duration = '0; wr_delay = '0;
        start = 1'b0; abort = 1'b0;
`ifdef TRIG_SEQ_LOOP_EN
        loop_count = 16'd0;
`endif
        #1 rst = 1'b1;
        test_reset();
        test_playback();
        test_full();
        test_empty_start();
        test_abort();
        test_timeout();
        test_reset_mid_playback();
`ifdef TRIG_SEQ_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_trig_cmd_sequencer
`default_nettype wire
